// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared widths, FSM state codes and helpers for the memory-stage controller.
// The state codes are plain 3-bit constants so they line up with the legacy
// MS_* encodings used elsewhere in the datapath.
package mem_access_ctrl_pkg;

    localparam int WORD     = 64;
    localparam int DM_DEPTH = 32;
    localparam int RD_W     = 5;
    localparam int FCNT_W   = 8;

    localparam logic [2:0] MS_IDLE     = 3'd0;
    localparam logic [2:0] MS_RD_ISSUE = 3'd1;
    localparam logic [2:0] MS_RD_CAPT  = 3'd2;
    localparam logic [2:0] MS_WR_ISSUE = 3'd3;
    localparam logic [2:0] MS_RESP     = 3'd4;

    typedef logic [WORD-1:0] word_t;

    // Everything writeback sees while a result is being held.
    typedef struct packed {
        word_t           data;
        logic [RD_W-1:0] rd;
        logic            regWrite;
        logic            fault;
    } wb_result_t;

    // Fault counter sticks at all-ones instead of wrapping.
    function automatic logic [FCNT_W-1:0] satInc(input logic [FCNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the three buses around the memory stage:
//   ex_*  : operation from EX/MEM (valid/ready handshake, ex_ready is the stall)
//   dm_*  : strobes, address and store data to the data memory, registered read data back
//   wb_*  : held result to writeback (valid/ready handshake), plus fault_cnt
// modport master : the controller's view (drives ex_ready, dm_*, wb_*, fault_cnt)
// modport slave  : the surrounding pipeline/memory view
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic              ex_valid;
    logic              ex_ready;
    logic              ex_mem_read;
    logic              ex_mem_write;
    word_t             ex_addr;
    word_t             ex_wdata;
    logic [RD_W-1:0]   ex_rd;
    logic              ex_reg_write;

    logic              dm_mem_read;
    logic              dm_mem_write;
    word_t             dm_addr;
    word_t             dm_wdata;
    word_t             dm_rdata;

    logic              wb_valid;
    logic              wb_ready;
    word_t             wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_reg_write;
    logic              wb_fault;
    logic [FCNT_W-1:0] fault_cnt;

    modport master (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, ex_rd, ex_reg_write,
        input  dm_rdata, wb_ready,
        output ex_ready, dm_mem_read, dm_mem_write, dm_addr, dm_wdata,
        output wb_valid, wb_data, wb_rd, wb_reg_write, wb_fault, fault_cnt
    );

    modport slave (
        output ex_valid, ex_mem_read, ex_mem_write, ex_addr, ex_wdata, ex_rd, ex_reg_write,
        output dm_rdata, wb_ready,
        input  ex_ready, dm_mem_read, dm_mem_write, dm_addr, dm_wdata,
        input  wb_valid, wb_data, wb_rd, wb_reg_write, wb_fault, fault_cnt
    );

endinterface

// File: rtl/mem_access_ctrl_addr_check.sv
// mem_addr_check
// Purely combinational access check for one EX/MEM operation.
//   addr         : byte address
//   mem_read     : load request
//   mem_write    : store request
//   misaligned   : memory op whose address is not on a word boundary
//   out_of_range : memory op whose address lies beyond the data memory
//   fault        : either of the above, or a load and store requested together
module mem_addr_check
    import mem_access_ctrl_pkg::*;
(
    input  word_t addr,
    input  logic  mem_read,
    input  logic  mem_write,
    output logic  misaligned,
    output logic  out_of_range,
    output logic  fault
);

    localparam word_t ADDR_LIMIT = word_t'(DM_DEPTH * 8);

    logic isMemOp;

    assign isMemOp      = mem_read || mem_write;
    assign misaligned   = isMemOp && (addr[2:0] != 3'b000);
    assign out_of_range = isMemOp && (addr >= ADDR_LIMIT);
    assign fault        = misaligned || out_of_range || (mem_read && mem_write);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage controller sitting directly in front of the data memory.
// Takes one EX/MEM operation at a time, issues a single-cycle registered
// read or write strobe, absorbs the memory's one-cycle read latency and
// holds the result for writeback until it is consumed.
//   im_clk : pipeline clock, all state on the rising edge
//   reset  : asynchronous, active-high
//   bus    : ex_* / dm_* / wb_* buses and fault_cnt (master view)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic              im_clk,
    input  logic              reset,
    mem_access_ctrl_if.master bus
);

    logic [2:0]        state_q,    state_d;
    word_t             dmAddr_q,   dmAddr_d;
    word_t             dmWdata_q,  dmWdata_d;
    logic              dmRead_q,   dmRead_d;
    logic              dmWrite_q,  dmWrite_d;
    logic [RD_W-1:0]   rd_q,       rd_d;
    logic              regWrite_q, regWrite_d;
    wb_result_t        wb_q,       wb_d;
    logic [FCNT_W-1:0] faultCnt_q, faultCnt_d;

    logic exReady;
    logic accept;
    logic chkMisaligned;
    logic chkOutOfRange;
    logic chkFault;
    logic opFault;

    mem_addr_check u_addr_check (
        .addr         (bus.ex_addr),
        .mem_read     (bus.ex_mem_read),
        .mem_write    (bus.ex_mem_write),
        .misaligned   (chkMisaligned),
        .out_of_range (chkOutOfRange),
        .fault        (chkFault)
    );

    // The checker's fault already contains both causes; folding them in
    // again keeps any cause flag from being silently dropped.
    assign opFault = chkFault || chkMisaligned || chkOutOfRange;

    // Ready stays low while reset is held so nothing is accepted mid-reset.
    // In RESP it follows wb_ready so a new op can replace the consumed one.
    assign exReady = !reset && ((state_q == MS_IDLE) || ((state_q == MS_RESP) && bus.wb_ready));
    assign accept  = bus.ex_valid && exReady;

    always_comb begin
        state_d    = state_q;
        dmAddr_d   = dmAddr_q;
        dmWdata_d  = dmWdata_q;
        dmRead_d   = 1'b0;
        dmWrite_d  = 1'b0;
        rd_d       = rd_q;
        regWrite_d = regWrite_q;
        wb_d       = wb_q;
        faultCnt_d = faultCnt_q;

        case (state_q)
            MS_IDLE: ;
            MS_RD_ISSUE: state_d = MS_RD_CAPT;
            MS_RD_CAPT: begin
                // Memory output is valid this cycle only; capture it now.
                state_d       = MS_RESP;
                wb_d.data     = bus.dm_rdata;
                wb_d.rd       = rd_q;
                wb_d.regWrite = regWrite_q;
                wb_d.fault    = 1'b0;
            end
            MS_WR_ISSUE: begin
                state_d       = MS_RESP;
                wb_d.data     = dmAddr_q;
                wb_d.rd       = rd_q;
                wb_d.regWrite = 1'b0;
                wb_d.fault    = 1'b0;
            end
            MS_RESP: begin
                if (bus.wb_ready) begin
                    state_d = MS_IDLE;
                end
            end
            default: state_d = MS_IDLE;
        endcase

        // An accept (from IDLE or a consumed RESP) overrides the above so
        // back-to-back operations enter their first state with no bubble.
        if (accept) begin
            rd_d       = bus.ex_rd;
            regWrite_d = bus.ex_reg_write;
            if (opFault) begin
                state_d       = MS_RESP;
                wb_d.data     = bus.ex_addr;
                wb_d.rd       = bus.ex_rd;
                wb_d.regWrite = 1'b0;
                wb_d.fault    = 1'b1;
                faultCnt_d    = satInc(faultCnt_q);
            end else if (bus.ex_mem_read) begin
                state_d  = MS_RD_ISSUE;
                dmRead_d = 1'b1;
                dmAddr_d = bus.ex_addr;
            end else if (bus.ex_mem_write) begin
                state_d   = MS_WR_ISSUE;
                dmWrite_d = 1'b1;
                dmAddr_d  = bus.ex_addr;
                dmWdata_d = bus.ex_wdata;
            end else begin
                state_d       = MS_RESP;
                wb_d.data     = bus.ex_addr;
                wb_d.rd       = bus.ex_rd;
                wb_d.regWrite = bus.ex_reg_write;
                wb_d.fault    = 1'b0;
            end
        end
    end

    // Async reset clears the strobes at once, so a store caught in
    // WR_ISSUE never reaches the memory's clock edge.
    always_ff @(posedge im_clk or posedge reset) begin
        if (reset) begin
            state_q    <= MS_IDLE;
            dmAddr_q   <= '0;
            dmWdata_q  <= '0;
            dmRead_q   <= 1'b0;
            dmWrite_q  <= 1'b0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
            wb_q       <= '0;
            faultCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dmAddr_q   <= dmAddr_d;
            dmWdata_q  <= dmWdata_d;
            dmRead_q   <= dmRead_d;
            dmWrite_q  <= dmWrite_d;
            rd_q       <= rd_d;
            regWrite_q <= regWrite_d;
            wb_q       <= wb_d;
            faultCnt_q <= faultCnt_d;
        end
    end

    assign bus.ex_ready     = exReady;
    assign bus.dm_mem_read  = dmRead_q;
    assign bus.dm_mem_write = dmWrite_q;
    assign bus.dm_addr      = dmAddr_q;
    assign bus.dm_wdata     = dmWdata_q;
    assign bus.wb_valid     = (state_q == MS_RESP);
    assign bus.wb_data      = wb_q.data;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_reg_write = wb_q.regWrite;
    assign bus.wb_fault     = wb_q.fault;
    assign bus.fault_cnt    = faultCnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Drives the memory-stage controller with directed and random operations and
// compares every observable against an operation-level model: a shadow copy
// of the data memory, a saturating fault tally and fixed per-kind latencies.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .im_clk (clk),
        .reset  (reset),
        .bus    (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Data memory with one-cycle registered read, loaded on the first edge.
    logic [63:0] mem [32];
    bit          memLoaded;

    // Reference model state.
    logic [63:0] refMem [32];
    int          refFaults;

    // Expectations for the operation in flight.
    logic        expRd, expWr, expFault, expRegWrite, expDataCare;
    logic [63:0] expData, expAddr, expWdata;
    logic [4:0]  expRdIdx;
    int          expLat;

    function automatic logic [63:0] initWord(input int i);
        return (i == 2) ? 64'hDEAD_BEEF : (64'hA5A5_0000_0000_0000 + 64'(i));
    endfunction

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end else begin
            if (bus.dm_mem_write) mem[bus.dm_addr[7:3]] <= bus.dm_wdata;
            if (bus.dm_mem_read)  bus.dm_rdata <= mem[bus.dm_addr[7:3]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_wb_valid"}, bus.wb_valid, 1'b1);
        if (expDataCare) checkOutput({tag, "_wb_data"}, bus.wb_data, expData);
        checkOutput({tag, "_wb_rd"}, bus.wb_rd, expRdIdx);
        checkOutput({tag, "_wb_reg_write"}, bus.wb_reg_write, expRegWrite);
        checkOutput({tag, "_wb_fault"}, bus.wb_fault, expFault);
        checkOutput({tag, "_fault_cnt"}, bus.fault_cnt, 64'(refFaults));
    endtask

    // Presents an op and works out what it should produce.
    task automatic startOp(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [4:0] rdIdx, input logic regw);
        bit bad;
        bad = ((rd || wr) && (((addr % 8) != 0) || (addr >= 64'd256))) || (rd && wr);
        expFault    = bad;
        expRd       = rd && !bad;
        expWr       = wr && !bad;
        expAddr     = addr;
        expWdata    = wdata;
        expRdIdx    = rdIdx;
        expRegWrite = (bad || wr) ? 1'b0 : regw;
        expDataCare = 1'b1;
        expData     = addr;
        if (bad) begin
            expLat = 1;
            if (refFaults < 255) refFaults++;
        end else if (rd) begin
            expData = refMem[int'(addr >> 3)];
            expLat  = 3;
        end else if (wr) begin
            refMem[int'(addr >> 3)] = wdata;
            expDataCare = 1'b0;
            expLat = 2;
        end else begin
            expLat = 1;
        end
        bus.ex_valid     = 1'b1;
        bus.ex_mem_read  = rd;
        bus.ex_mem_write = wr;
        bus.ex_addr      = addr;
        bus.ex_wdata     = wdata;
        bus.ex_rd        = rdIdx;
        bus.ex_reg_write = regw;
    endtask

    // Expects the accept on the next rising edge, follows the op into RESP
    // and keeps the result held for holdCycles extra cycles.
    task automatic finishOp(input int holdCycles);
        int k;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.wb_ready = 1'b0;
        k = 1;
        checkOutput("dm_mem_read_T1", bus.dm_mem_read, expRd);
        checkOutput("dm_mem_write_T1", bus.dm_mem_write, expWr);
        if (expRd || expWr) checkOutput("dm_addr", bus.dm_addr, expAddr);
        if (expWr) checkOutput("dm_wdata", bus.dm_wdata, expWdata);
        while (bus.wb_valid !== 1'b1 && k < 8) begin
            checkOutput("ex_ready_busy", bus.ex_ready, 1'b0);
            @(negedge clk);
            k++;
            checkOutput("strobe_one_cycle", {bus.dm_mem_read, bus.dm_mem_write}, 2'b00);
        end
        checkOutput("latency", 64'(k), 64'(expLat));
        checkResult("resp");
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("ex_ready_hold", bus.ex_ready, 1'b0);
            checkResult("hold");
        end
    endtask

    task automatic releaseResult();
        bus.wb_ready = 1'b1;
        #1;
        checkOutput("ex_ready_on_wb_ready", bus.ex_ready, 1'b1);
        @(negedge clk);
        checkOutput("wb_valid_drop", bus.wb_valid, 1'b0);
        bus.wb_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [4:0] rdIdx,
                                 input logic regw, input int holdCycles);
        startOp(rd, wr, addr, wdata, rdIdx, regw);
        finishOp(holdCycles);
        releaseResult();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] savedData, savedWord;
        logic [4:0]  savedRd;

        for (int i = 0; i < 32; i++) refMem[i] = initWord(i);
        refFaults        = 0;
        reset            = 1'b1;
        bus.ex_valid     = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_mem_write = 1'b0;
        bus.ex_addr      = '0;
        bus.ex_wdata     = '0;
        bus.ex_rd        = '0;
        bus.ex_reg_write = 1'b0;
        bus.wb_ready     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_dm_mem_read", bus.dm_mem_read, 1'b0);
        checkOutput("rst_dm_mem_write", bus.dm_mem_write, 1'b0);
        checkOutput("rst_dm_addr", bus.dm_addr, 64'h0);
        checkOutput("rst_dm_wdata", bus.dm_wdata, 64'h0);
        checkOutput("rst_wb_valid", bus.wb_valid, 1'b0);
        checkOutput("rst_wb_data", bus.wb_data, 64'h0);
        checkOutput("rst_fault_cnt", bus.fault_cnt, 64'h0);
        checkOutput("rst_ex_ready", bus.ex_ready, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ex_ready", bus.ex_ready, 1'b1);

        // Load of preloaded word, store then read back.
        applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 5'd5, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 64'h18, 64'h1234, 5'd3, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 64'h18, 64'h0, 5'd6, 1'b1, 1);

        // Faults, plus the last valid word and first invalid address.
        applyStimulus(1'b1, 1'b0, 64'h0C, 64'h0, 5'd4, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 64'h100, 64'h77, 5'd4, 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 64'hF8, 64'hCAFE_F00D, 5'd1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 64'hF8, 64'h0, 5'd2, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 64'h20, 64'h0, 5'd2, 1'b1, 0);

        // Non-memory op held 4 cycles with the next op waiting, then back-to-back.
        startOp(1'b0, 1'b0, 64'h55, 64'h0, 5'd7, 1'b1);
        finishOp(0);
        savedData = expData;
        savedRd   = expRdIdx;
        startOp(1'b1, 1'b0, 64'h18, 64'h0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_ex_ready", bus.ex_ready, 1'b0);
            checkOutput("stall_wb_valid", bus.wb_valid, 1'b1);
            checkOutput("stall_wb_data", bus.wb_data, savedData);
            checkOutput("stall_wb_rd", bus.wb_rd, savedRd);
        end
        bus.wb_ready = 1'b1;
        #1;
        checkOutput("b2b_ex_ready", bus.ex_ready, 1'b1);
        finishOp(0);
        releaseResult();

        // Reset during RD_ISSUE.
        startOp(1'b1, 1'b0, 64'h20, 64'h0, 5'd8, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        checkOutput("pre_rst_rd_strobe", bus.dm_mem_read, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst_rd_strobe", bus.dm_mem_read, 1'b0);
        checkOutput("rst_rd_wb_valid", bus.wb_valid, 1'b0);
        checkOutput("rst_rd_fault_cnt", bus.fault_cnt, 64'h0);
        refFaults = 0;
        @(negedge clk);
        reset = 1'b0;

        // Reset during WR_ISSUE: the store must not land.
        savedWord = refMem[5];
        startOp(1'b0, 1'b1, 64'h28, 64'hBAD0_BAD0, 5'd8, 1'b0);
        refMem[5] = savedWord;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        checkOutput("pre_rst_wr_strobe", bus.dm_mem_write, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst_wr_strobe", bus.dm_mem_write, 1'b0);
        checkOutput("rst_wr_wb_valid", bus.wb_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_wr_ex_ready", bus.ex_ready, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h28, 64'h0, 5'd10, 1'b1, 0);

        // Random mix.
        for (int n = 0; n < 40; n++) begin
            int          sel, pick;
            logic [63:0] a;
            logic        r, w;
            sel  = $urandom_range(0, 9);
            pick = $urandom_range(0, 9);
            r = (sel <= 3) || (sel == 9);
            w = ((sel >= 4) && (sel <= 6)) || (sel == 9);
            if (pick == 0)      a = (64'($urandom_range(0, 31)) << 3) + 64'($urandom_range(1, 7));
            else if (pick == 1) a = {$urandom, $urandom} | 64'h100;
            else if (!r && !w)  a = {$urandom, $urandom};
            else                a = 64'($urandom_range(0, 31)) << 3;
            applyStimulus(r, w, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Drive the fault counter into saturation.
        for (int n = 0; n < 260; n++) begin
            applyStimulus(1'b1, 1'b0, 64'h3, 64'h0, 5'd1, 1'b1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
